// File: rtl/corr_pkg.sv
// -----------------------------------------------------------------------------
// corr_pkg
// Definitions shared by the correlation scan controller and the correlation
// scorer. It holds the default coordinate and score widths, the matching
// coordinate and score types, and the scan controller state encoding.
// -----------------------------------------------------------------------------
package corr_pkg;

  localparam int COORD_W = 13;
  localparam int SCORE_W = 16;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [SCORE_W-1:0] score_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    UPDATE = 3'd4,
    DONE   = 3'd5
  } scan_state_e;

endpackage

// File: rtl/corr_best_tracker.sv
// -----------------------------------------------------------------------------
// corr_best_tracker
// Keeps the lowest score seen during a scan and the coordinates that produced
// it. A new score replaces the stored one only when it is strictly lower, so
// on a tie the earlier raster point is kept.
//
// Ports:
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   clr_i        clear best registers and the valid flag (new scan accepted)
//   upd_i        offer score_i / x_i / y_i as a candidate
//   score_i      candidate score
//   x_i, y_i     candidate coordinates
//   best_x_o     best candidate X
//   best_y_o     best candidate Y
//   best_score_o best (minimum) score
//   best_valid_o at least one candidate has been offered since the last clear
// -----------------------------------------------------------------------------
module corr_best_tracker #(
  parameter int COORD_W = 13,
  parameter int SCORE_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               upd_i,
  input  logic [SCORE_W-1:0] score_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output logic [COORD_W-1:0] best_x_o,
  output logic [COORD_W-1:0] best_y_o,
  output logic [SCORE_W-1:0] best_score_o,
  output logic               best_valid_o
);

  logic [COORD_W-1:0] best_x_q;
  logic [COORD_W-1:0] best_y_q;
  logic [SCORE_W-1:0] best_score_q;
  logic               best_valid_q;
  logic               take_new;

  // First score of a scan is always taken; afterwards only a strictly lower one.
  assign take_new = upd_i && (!best_valid_q || (score_i < best_score_q));

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      best_x_q     <= '0;
      best_y_q     <= '0;
      best_score_q <= '0;
      best_valid_q <= 1'b0;
    end else if (take_new) begin
      best_x_q     <= x_i;
      best_y_q     <= y_i;
      best_score_q <= score_i;
      best_valid_q <= 1'b1;
    end
  end

  assign best_x_o     = best_x_q;
  assign best_y_o     = best_y_q;
  assign best_score_o = best_score_q;
  assign best_valid_o = best_valid_q;

endmodule

// File: rtl/corr_scan_ctrl.sv
// -----------------------------------------------------------------------------
// corr_scan_ctrl
// Sweeps candidate window origins over a SEARCH_W x SEARCH_H area in raster
// order, launches the correlation scorer for each candidate, waits for the
// score, and keeps the lowest score with its coordinates.
//
// Optional feature macro: CORR_SCAN_TIMEOUT_EN
//   defined   : per-candidate watchdog of TIMEOUT_CYC cycles in WAIT; expiry
//               sets the sticky oTimeout flag and returns to IDLE, no oDone.
//   undefined : WAIT has no limit and oTimeout is tied low.
//
// Ports:
//   iCLK, iRST_N           clock, synchronous active-low reset
//   iStart, iAbort         start (IDLE only) / abort scan
//   iXorigin, iYorigin     scan origin, latched on accepted start
//   oXstart, oYstart       candidate coordinates to the scorer
//   oCorrStart             one-cycle scorer launch pulse
//   iCorrFinished          scorer finished flag (rising edge used)
//   iCorrScore             scorer result, valid on the finished rising edge
//   oBusy, oDone           not-IDLE flag / scan-complete pulse
//   oBestX/Y/Score/Valid   best match of the current or last scan
//   oTimeout               sticky watchdog flag
// -----------------------------------------------------------------------------
module corr_scan_ctrl #(
  parameter int COORD_W     = 13,
  parameter int SCORE_W     = 16,
  parameter int SEARCH_W    = 64,
  parameter int SEARCH_H    = 48,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iStart,
  input  logic               iAbort,
  input  logic [COORD_W-1:0] iXorigin,
  input  logic [COORD_W-1:0] iYorigin,
  output logic [COORD_W-1:0] oXstart,
  output logic [COORD_W-1:0] oYstart,
  output logic               oCorrStart,
  input  logic               iCorrFinished,
  input  logic [SCORE_W-1:0] iCorrScore,
  output logic               oBusy,
  output logic               oDone,
  output logic [COORD_W-1:0] oBestX,
  output logic [COORD_W-1:0] oBestY,
  output logic [SCORE_W-1:0] oBestScore,
  output logic               oBestValid,
  output logic               oTimeout
);

  import corr_pkg::*;

  localparam int XOFF_W = (SEARCH_W > 1) ? $clog2(SEARCH_W) : 1;
  localparam int YOFF_W = (SEARCH_H > 1) ? $clog2(SEARCH_H) : 1;
  localparam logic [XOFF_W-1:0] X_LAST = XOFF_W'(SEARCH_W - 1);
  localparam logic [YOFF_W-1:0] Y_LAST = YOFF_W'(SEARCH_H - 1);

  if (SEARCH_W < 1 || SEARCH_H < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("corr_scan_ctrl: SEARCH_W, SEARCH_H and TIMEOUT_CYC must be >= 1");
  end

  scan_state_e        state_q, state_d;
  logic [COORD_W-1:0] xorg_q, xorg_d, yorg_q, yorg_d;
  logic [XOFF_W-1:0]  xoff_q, xoff_d;
  logic [YOFF_W-1:0]  yoff_q, yoff_d;
  logic [COORD_W-1:0] xstart_q, ystart_q;
  logic [SCORE_W-1:0] score_q;
  logic               fin_q;
  logic               corr_start_q, busy_q, done_q;
  logic               fin_rise, start_acc, timeout_hit;

  // fin_q follows the input every cycle, so a level held high from an earlier
  // candidate never looks like a new edge once WAIT is entered.
  assign fin_rise  = iCorrFinished && !fin_q;
  assign start_acc = (state_q == IDLE) && iStart;

`ifdef CORR_SCAN_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [TCNT_W-1:0] tcnt_q;
  logic              timeout_q;

  // tcnt_q is 0 on the first WAIT cycle, so expiry is on the TIMEOUT_CYC-th.
  assign timeout_hit = (state_q == WAIT) && !fin_rise &&
                       (tcnt_q == TCNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q <= (state_q == WAIT) ? tcnt_q + 1'b1 : '0;
      if (start_acc)
        timeout_q <= 1'b0;
      else if (timeout_hit && !iAbort)
        timeout_q <= 1'b1;
    end
  end

  assign oTimeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign oTimeout    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    xorg_d  = xorg_q;
    yorg_d  = yorg_q;
    xoff_d  = xoff_q;
    yoff_d  = yoff_q;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d = LOAD;
          xorg_d  = iXorigin;
          yorg_d  = iYorigin;
          xoff_d  = '0;
          yoff_d  = '0;
        end
      end
      LOAD:  state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (fin_rise)
          state_d = UPDATE;
        else if (timeout_hit)
          state_d = IDLE;
      end
      UPDATE: begin
        if (xoff_q == X_LAST) begin
          xoff_d = '0;
          yoff_d = yoff_q + 1'b1;
        end else begin
          xoff_d = xoff_q + 1'b1;
        end
        state_d = ((xoff_q == X_LAST) && (yoff_q == Y_LAST)) ? DONE : LOAD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (iAbort && (state_q != IDLE))
      state_d = IDLE;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q      <= IDLE;
      xorg_q       <= '0;
      yorg_q       <= '0;
      xoff_q       <= '0;
      yoff_q       <= '0;
      xstart_q     <= '0;
      ystart_q     <= '0;
      score_q      <= '0;
      fin_q        <= 1'b0;
      corr_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      xorg_q  <= xorg_d;
      yorg_q  <= yorg_d;
      xoff_q  <= xoff_d;
      yoff_q  <= yoff_d;
      fin_q   <= iCorrFinished;
      // Coordinates are registered on entry to LOAD, giving the scorer one
      // full cycle of stable coordinates before the ISSUE pulse.
      if (state_d == LOAD) begin
        xstart_q <= xorg_d + COORD_W'(xoff_d);
        ystart_q <= yorg_d + COORD_W'(yoff_d);
      end
      if ((state_q == WAIT) && fin_rise)
        score_q <= iCorrScore;
      corr_start_q <= (state_d == ISSUE);
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == DONE);
    end
  end

  // xstart_q/ystart_q still hold the scored candidate during UPDATE.
  corr_best_tracker #(
    .COORD_W (COORD_W),
    .SCORE_W (SCORE_W)
  ) u_best (
    .clk_i        (iCLK),
    .rst_ni       (iRST_N),
    .clr_i        (start_acc),
    .upd_i        (state_q == UPDATE),
    .score_i      (score_q),
    .x_i          (xstart_q),
    .y_i          (ystart_q),
    .best_x_o     (oBestX),
    .best_y_o     (oBestY),
    .best_score_o (oBestScore),
    .best_valid_o (oBestValid)
  );

  assign oXstart    = xstart_q;
  assign oYstart    = ystart_q;
  assign oCorrStart = corr_start_q;
  assign oBusy      = busy_q;
  assign oDone      = done_q;

endmodule

// File: tb/tb_corr_scan_ctrl.sv
module tb_corr_scan_ctrl;

  localparam int CW = 13;
  localparam int SW = 16;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int TC = 16;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic          iStart = 1'b0;
  logic          iAbort = 1'b0;
  logic [CW-1:0] iXorigin = '0;
  logic [CW-1:0] iYorigin = '0;
  logic          iCorrFinished = 1'b0;
  logic [SW-1:0] iCorrScore = '0;
  logic [CW-1:0] oXstart, oYstart, oBestX, oBestY;
  logic [SW-1:0] oBestScore;
  logic          oCorrStart, oBusy, oDone, oBestValid, oTimeout;

  int vec_cnt = 0;
  int err_cnt = 0;

  corr_scan_ctrl #(
    .COORD_W (CW), .SCORE_W (SW), .SEARCH_W (W), .SEARCH_H (H), .TIMEOUT_CYC (TC)
  ) dut (
    .iCLK          (iCLK),
    .iRST_N        (iRST_N),
    .iStart        (iStart),
    .iAbort        (iAbort),
    .iXorigin      (iXorigin),
    .iYorigin      (iYorigin),
    .oXstart       (oXstart),
    .oYstart       (oYstart),
    .oCorrStart    (oCorrStart),
    .iCorrFinished (iCorrFinished),
    .iCorrScore    (iCorrScore),
    .oBusy         (oBusy),
    .oDone         (oDone),
    .oBestX        (oBestX),
    .oBestY        (oBestY),
    .oBestScore    (oBestScore),
    .oBestValid    (oBestValid),
    .oTimeout      (oTimeout)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // mode: 0 random scores, 1 distance to (12,21), 2 all five, 3 scorer never answers
  // hold: finished level stays high between candidates, with a bogus score
  // abort_at: candidate index aborted in WAIT (-1 for none)
  task automatic run_scan(input int xo, input int yo, input int mode, input bit hold,
                          input int abort_at, input bit noise);
    int ex[N], ey[N], sc[N];
    int n_scored, bx, by, bs, launches, dones, t, lat, cyc, cur;
    bit bv, active, finished;
    n_scored = (mode == 3) ? 0 : ((abort_at >= 0) ? abort_at : N);
    for (int i = 0; i < N; i++) begin
      ex[i] = (xo + i % W) % 8192;
      ey[i] = (yo + i / W) % 8192;
      case (mode)
        1:       sc[i] = iabs(ex[i] - 12) + iabs(ey[i] - 21);
        2:       sc[i] = 5;
        default: sc[i] = $urandom_range(0, 7);
      endcase
    end
    // reference: raster order, strictly lower replaces, ties keep earliest
    bv = 0; bx = 0; by = 0; bs = 0;
    for (int i = 0; i < n_scored; i++)
      if (!bv || sc[i] < bs) begin bv = 1; bx = ex[i]; by = ey[i]; bs = sc[i]; end

    launches = 0; dones = 0; t = 0; lat = 1; cyc = 0; cur = 0;
    active = 0; finished = 0;
    @(negedge iCLK);
    iCorrFinished = hold; iXorigin = CW'(xo); iYorigin = CW'(yo); iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0; iXorigin = CW'($urandom); iYorigin = CW'($urandom);
    check("busy_after_start", oBusy, 1);
    check("valid_cleared", oBestValid, 0);
    check("score_cleared", oBestScore, 0);
    check("timeout_cleared", oTimeout, 0);

    while (!finished) begin
      @(negedge iCLK);
      cyc++;
      iStart = 1'b0;
      if (cyc > 500) begin check("cycle_budget", 0, 1); break; end
      if (oDone) begin dones++; finished = 1; end
      if (oCorrStart) begin
        if (launches < N) begin
          check("launch_x", oXstart, ex[launches]);
          check("launch_y", oYstart, ey[launches]);
        end
        cur = launches; launches++;
        active = 1; t = 0; lat = $urandom_range(1, 4);
      end else if (active) begin
        t++;
      end
      if (active && !finished) begin
        if (mode == 3) begin
          if (!oBusy) begin
            check("timeout_wait_len", t, TC + 1);
            check("timeout_flag", oTimeout, 1);
            finished = 1;
          end
        end else if (cur == abort_at) begin
          if (t == 1) iAbort = 1'b1;
          else if (t == 2) begin
            iAbort = 1'b0;
            check("busy_after_abort", oBusy, 0);
          end else if (t == 10) finished = 1;
        end else if (!hold) begin
          if (t == lat) begin iCorrFinished = 1'b1; iCorrScore = SW'(sc[cur]); end
          else begin iCorrFinished = 1'b0; iCorrScore = SW'($urandom); end
        end else begin
          if (t == 1) iCorrScore = '0;
          else if (t == lat + 1) iCorrFinished = 1'b0;
          else if (t == lat + 2) begin iCorrFinished = 1'b1; iCorrScore = SW'(sc[cur]); end
        end
        if (noise && t == 1 && cur != abort_at) begin
          iStart = 1'b1; iXorigin = CW'($urandom); iYorigin = CW'($urandom);
        end
      end
    end
    iStart = 1'b0;

    if (mode == 3) begin
      check("launch_count", launches, 1);
      check("done_count", dones, 0);
    end else if (abort_at >= 0) begin
      check("launch_count", launches, abort_at + 1);
      check("done_count", dones, 0);
    end else begin
      check("launch_count", launches, N);
      check("done_count", dones, 1);
      @(negedge iCLK);
      check("busy_after_done", oBusy, 0);
      repeat (3) @(negedge iCLK);
      check("done_pulse_width", oDone, 0);
    end
    check("best_x", oBestX, bx);
    check("best_y", oBestY, by);
    check("best_score", oBestScore, bs);
    check("best_valid", oBestValid, bv);
    $display("scan org=(%0d,%0d) mode=%0d hold=%0d abort_at=%0d -> best (%0d,%0d,%0d) valid=%0d",
             xo, yo, mode, hold, abort_at, oBestX, oBestY, oBestScore, oBestValid);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (3) @(negedge iCLK);
    check("rst_busy", oBusy, 0);
    check("rst_done", oDone, 0);
    check("rst_corr_start", oCorrStart, 0);
    check("rst_xstart", oXstart, 0);
    check("rst_ystart", oYstart, 0);
    check("rst_best_valid", oBestValid, 0);
    check("rst_best_score", oBestScore, 0);
    check("rst_timeout", oTimeout, 0);
    iRST_N = 1'b1;
    @(negedge iCLK);
    iAbort = 1'b1;          // abort in IDLE has no effect
    @(negedge iCLK);
    iAbort = 1'b0;
    check("idle_abort_busy", oBusy, 0);

    run_scan(10, 20, 1, 0, -1, 0);    // distance scores: best (12,21,0)
    run_scan(10, 20, 2, 0, -1, 0);    // all ties: first point wins
    run_scan(8190, 0, 0, 0, -1, 0);   // X wrap 8190,8191,0,1
    run_scan(10, 20, 0, 0, 2, 1);     // abort in WAIT of 3rd candidate
    run_scan(300, 40, 0, 1, -1, 0);   // finished held high between candidates
    run_scan(5, 8191, 0, 1, -1, 1);   // Y wrap with held finished
    for (int k = 0; k < 6; k++)
      run_scan(int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)), 0,
               bit'($urandom_range(0, 1)), -1, 1);
`ifdef CORR_SCAN_TIMEOUT_EN
    run_scan(100, 200, 3, 0, -1, 0);  // scorer never answers
    run_scan(100, 200, 0, 0, -1, 0);  // next start clears the flag
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
